// File: rtl/gaussian_line_scheduler.sv
// Turns one host row stream into the three row-aligned streams (k-1, k, k+1) of a 3-line filter.
// Two row buffers hold the previous rows; their OLD/MID roles swap at every row boundary.
module gaussian_line_scheduler #(
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned MAX_WORDS = 1024,
    parameter int unsigned ADDR_W    = 10
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [ADDR_W:0]   i_width_words,
    input  logic [15:0]       i_num_lines,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    input  logic              i_in_data_valid,
    input  logic [DATA_W-1:0] i_in_data,
    output logic              o_in_data_ack,
    output logic              o_line1_data_valid,
    output logic [DATA_W-1:0] o_line1_data,
    input  logic              i_line1_data_ack,
    output logic              o_line2_data_valid,
    output logic [DATA_W-1:0] o_line2_data,
    input  logic              i_line2_data_ack,
    output logic              o_line3_data_valid,
    output logic [DATA_W-1:0] o_line3_data,
    input  logic              i_line3_data_ack
);

    localparam logic [ADDR_W:0] MaxWords = MAX_WORDS[ADDR_W:0];

    typedef enum logic [2:0] {StIdle, StPrime0, StPrime1, StStream, StDone} state_e;

    state_e              state_q;
    logic [ADDR_W:0]     width_q;
    logic [15:0]         lines_q;
    logic [15:0]         row_q;
    logic [ADDR_W-1:0]   col_q;
    logic                old_is_b_q;
    logic [2:0]          vld_q;
    logic [2:0]          vld_d;
    logic [DATA_W-1:0]   line1_q;
    logic [DATA_W-1:0]   line2_q;
    logic [DATA_W-1:0]   line3_q;
    logic                busy_q;
    logic                done_q;
    logic                err_q;

    logic [DATA_W-1:0]   mem_a [MAX_WORDS];
    logic [DATA_W-1:0]   mem_b [MAX_WORDS];

    logic                in_ack;
    logic                accept;
    logic [ADDR_W:0]     last_idx;
    logic                last_col;
    logic                bad_cfg;
    logic [2:0]          line_ack;
    logic [DATA_W-1:0]   old_rd;
    logic [DATA_W-1:0]   mid_rd;

    // Input is only taken while no tuple is outstanding, so at most one tuple is ever in flight.
    assign in_ack   = (state_q == StPrime0) || (state_q == StPrime1) ||
                      ((state_q == StStream) && (vld_q == 3'b000));
    assign accept   = in_ack && i_in_data_valid;
    assign last_idx = width_q - (ADDR_W + 1)'(1);
    assign last_col = ({1'b0, col_q} == last_idx);
    assign bad_cfg  = (i_width_words == '0) || (i_width_words > MaxWords) ||
                      (i_num_lines < 16'd3);
    assign line_ack = {i_line3_data_ack, i_line2_data_ack, i_line1_data_ack};
    assign old_rd   = old_is_b_q ? mem_b[col_q] : mem_a[col_q];
    assign mid_rd   = old_is_b_q ? mem_a[col_q] : mem_b[col_q];

    always_comb begin
        vld_d = vld_q & ~line_ack;
        if ((state_q == StStream) && accept) begin
            vld_d = 3'b111;
        end
    end

    // Asynchronous read above sees the old row before this edge overwrites it with the new one.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            if ((state_q == StPrime0) || ((state_q == StStream) && !old_is_b_q)) begin
                mem_a[col_q] <= i_in_data;
            end
            if ((state_q == StPrime1) || ((state_q == StStream) && old_is_b_q)) begin
                mem_b[col_q] <= i_in_data;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= StIdle;
            width_q    <= '0;
            lines_q    <= '0;
            row_q      <= '0;
            col_q      <= '0;
            old_is_b_q <= 1'b0;
            vld_q      <= '0;
            line1_q    <= '0;
            line2_q    <= '0;
            line3_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (i_start) begin
                        width_q    <= i_width_words;
                        lines_q    <= i_num_lines;
                        col_q      <= '0;
                        row_q      <= '0;
                        old_is_b_q <= 1'b0;
                        busy_q     <= 1'b1;
                        err_q      <= bad_cfg;
                        if (bad_cfg) begin
                            done_q  <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            state_q <= StPrime0;
                        end
                    end
                end
                StPrime0: begin
                    if (accept) begin
                        if (last_col) begin
                            col_q   <= '0;
                            state_q <= StPrime1;
                        end else begin
                            col_q <= col_q + ADDR_W'(1);
                        end
                    end
                end
                StPrime1: begin
                    if (accept) begin
                        if (last_col) begin
                            col_q   <= '0;
                            row_q   <= 16'd2;
                            state_q <= StStream;
                        end else begin
                            col_q <= col_q + ADDR_W'(1);
                        end
                    end
                end
                StStream: begin
                    vld_q <= vld_d;
                    if (accept) begin
                        line1_q <= old_rd;
                        line2_q <= mid_rd;
                        line3_q <= i_in_data;
                        if (last_col) begin
                            col_q      <= '0;
                            row_q      <= row_q + 16'd1;
                            old_is_b_q <= ~old_is_b_q;
                        end else begin
                            col_q <= col_q + ADDR_W'(1);
                        end
                    end
                    // row_q has already stepped past the last row once its final word was taken.
                    if ((row_q == lines_q) && (vld_d == 3'b000)) begin
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign o_busy             = busy_q;
    assign o_done             = done_q;
    assign o_err              = err_q;
    assign o_in_data_ack      = in_ack;
    assign o_line1_data_valid = vld_q[0];
    assign o_line2_data_valid = vld_q[1];
    assign o_line3_data_valid = vld_q[2];
    assign o_line1_data       = line1_q;
    assign o_line2_data       = line2_q;
    assign o_line3_data       = line3_q;

endmodule
